mips_decode_ctrl: RTL and testbench

Multi-cycle control and decode unit for the MIPS CPU. It latches each instruction word, sequences the fetch/exec1/exec2 phases, and decodes the word into the CPU-wide 7-bit op enumeration plus operand fields. These drive the ALU, register file and memory interface. It stalls on memory `waitrequest` and halts on an unsupported encoding.

---
 rtl/mips_decode_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_mips_decode_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_decode_ctrl.sv
// Multi-cycle fetch/exec1/exec2 sequencer and instruction decoder for the MIPS core.
// Latency: 3 cycles per instruction (FETCH, EXEC1, EXEC2); decode outputs are combinational from IR.
// Backpressure: waitrequest stalls FETCH and EXEC2 of load/store ops; unsupported words halt until reset.
module mips_decode_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        fetch,
    output logic        exec1,
    output logic        exec2,
    output logic        active,
    output logic        invalid,
    output logic [6:0]  op,
    output logic [5:0]  sa,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  dest,
    output logic [31:0] imm,
    output logic [25:0] target,
    output logic        reg_write
);

    // CPU-wide op enumeration: ALU ops 1-29, branches/jumps 30-41, memory-side ops 42-52.
    localparam logic [6:0] OP_NONE   = 7'd0;
    localparam logic [6:0] OP_ADD    = 7'd1;
    localparam logic [6:0] OP_ADDI   = 7'd2;
    localparam logic [6:0] OP_ADDIU  = 7'd3;
    localparam logic [6:0] OP_ADDU   = 7'd4;
    localparam logic [6:0] OP_AND    = 7'd5;
    localparam logic [6:0] OP_ANDI   = 7'd6;
    localparam logic [6:0] OP_DIV    = 7'd7;
    localparam logic [6:0] OP_DIVU   = 7'd8;
    localparam logic [6:0] OP_MFHI   = 7'd9;
    localparam logic [6:0] OP_MFLO   = 7'd10;
    localparam logic [6:0] OP_MTHI   = 7'd11;
    localparam logic [6:0] OP_MTLO   = 7'd12;
    localparam logic [6:0] OP_MULT   = 7'd13;
    localparam logic [6:0] OP_MULTU  = 7'd14;
    localparam logic [6:0] OP_OR     = 7'd15;
    localparam logic [6:0] OP_ORI    = 7'd16;
    localparam logic [6:0] OP_SLL    = 7'd17;
    localparam logic [6:0] OP_SLLV   = 7'd18;
    localparam logic [6:0] OP_SLT    = 7'd19;
    localparam logic [6:0] OP_SLTI   = 7'd20;
    localparam logic [6:0] OP_SLTIU  = 7'd21;
    localparam logic [6:0] OP_SLTU   = 7'd22;
    localparam logic [6:0] OP_SRA    = 7'd23;
    localparam logic [6:0] OP_SRAV   = 7'd24;
    localparam logic [6:0] OP_SRL    = 7'd25;
    localparam logic [6:0] OP_SRLV   = 7'd26;
    localparam logic [6:0] OP_SUBU   = 7'd27;
    localparam logic [6:0] OP_XOR    = 7'd28;
    localparam logic [6:0] OP_XORI   = 7'd29;
    localparam logic [6:0] OP_BEQ    = 7'd30;
    localparam logic [6:0] OP_BGEZ   = 7'd31;
    localparam logic [6:0] OP_BGEZAL = 7'd32;
    localparam logic [6:0] OP_BGTZ   = 7'd33;
    localparam logic [6:0] OP_BLEZ   = 7'd34;
    localparam logic [6:0] OP_BLTZ   = 7'd35;
    localparam logic [6:0] OP_BLTZAL = 7'd36;
    localparam logic [6:0] OP_BNE    = 7'd37;
    localparam logic [6:0] OP_J      = 7'd38;
    localparam logic [6:0] OP_JAL    = 7'd39;
    localparam logic [6:0] OP_JALR   = 7'd40;
    localparam logic [6:0] OP_JR     = 7'd41;
    localparam logic [6:0] OP_LB     = 7'd42;
    localparam logic [6:0] OP_LBU    = 7'd43;
    localparam logic [6:0] OP_LH     = 7'd44;
    localparam logic [6:0] OP_LHU    = 7'd45;
    localparam logic [6:0] OP_LUI    = 7'd46;
    localparam logic [6:0] OP_LW     = 7'd47;
    localparam logic [6:0] OP_LWL    = 7'd48;
    localparam logic [6:0] OP_LWR    = 7'd49;
    localparam logic [6:0] OP_SB     = 7'd50;
    localparam logic [6:0] OP_SH     = 7'd51;
    localparam logic [6:0] OP_SW     = 7'd52;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC1  = 2'd1,
        S_EXEC2  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] ir;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic        is_mem;
    logic        op_writes;

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];
    assign rd     = ir[15:11];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign sa     = {1'b0, ir[10:6]};
    assign target = ir[25:0];

    // The whole 42..52 block (including LUI) shares the memory-side EXEC2 stall rule.
    assign is_mem = (op >= OP_LB) && (op <= OP_SW);

    // Phase sequencer; also owns the instruction register so IR only moves on the edge leaving FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            ir      <= 32'h0;
            fetch   <= 1'b1;
            exec1   <= 1'b0;
            exec2   <= 1'b0;
            active  <= 1'b1;
            invalid <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!waitrequest) begin
                        ir    <= readdata;
                        state <= S_EXEC1;
                        fetch <= 1'b0;
                        exec1 <= 1'b1;
                    end
                end
                S_EXEC1: begin
                    exec1 <= 1'b0;
                    if (op == OP_NONE) begin
                        invalid <= 1'b1;
                        active  <= 1'b0;
                        state   <= S_HALTED;
                    end else begin
                        exec2 <= 1'b1;
                        state <= S_EXEC2;
                    end
                end
                S_EXEC2: begin
                    if (!(is_mem && waitrequest)) begin
                        exec2 <= 1'b0;
                        fetch <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state <= S_HALTED;
                end
            endcase
        end
    end

    // Opcode / funct / regimm-rt decode into the op enumeration; anything unlisted is OP_NONE.
    always_comb begin
        op = OP_NONE;
        case (opcode)
            6'd0: begin
                case (funct)
                    6'd0:    op = OP_SLL;
                    6'd2:    op = OP_SRL;
                    6'd3:    op = OP_SRA;
                    6'd4:    op = OP_SLLV;
                    6'd6:    op = OP_SRLV;
                    6'd7:    op = OP_SRAV;
                    6'd8:    op = OP_JR;
                    6'd9:    op = OP_JALR;
                    6'd16:   op = OP_MFHI;
                    6'd17:   op = OP_MTHI;
                    6'd18:   op = OP_MFLO;
                    6'd19:   op = OP_MTLO;
                    6'd24:   op = OP_MULT;
                    6'd25:   op = OP_MULTU;
                    6'd26:   op = OP_DIV;
                    6'd27:   op = OP_DIVU;
                    6'd32:   op = OP_ADD;
                    6'd33:   op = OP_ADDU;
                    6'd35:   op = OP_SUBU;
                    6'd36:   op = OP_AND;
                    6'd37:   op = OP_OR;
                    6'd38:   op = OP_XOR;
                    6'd42:   op = OP_SLT;
                    6'd43:   op = OP_SLTU;
                    default: op = OP_NONE;
                endcase
            end
            6'd1: begin
                case (rt)
                    5'd0:    op = OP_BLTZ;
                    5'd1:    op = OP_BGEZ;
                    5'd16:   op = OP_BLTZAL;
                    5'd17:   op = OP_BGEZAL;
                    default: op = OP_NONE;
                endcase
            end
            6'd2:    op = OP_J;
            6'd3:    op = OP_JAL;
            6'd4:    op = OP_BEQ;
            6'd5:    op = OP_BNE;
            6'd6:    op = OP_BLEZ;
            6'd7:    op = OP_BGTZ;
            6'd8:    op = OP_ADDI;
            6'd9:    op = OP_ADDIU;
            6'd10:   op = OP_SLTI;
            6'd11:   op = OP_SLTIU;
            6'd12:   op = OP_ANDI;
            6'd13:   op = OP_ORI;
            6'd14:   op = OP_XORI;
            6'd15:   op = OP_LUI;
            6'd32:   op = OP_LB;
            6'd33:   op = OP_LH;
            6'd34:   op = OP_LWL;
            6'd35:   op = OP_LW;
            6'd36:   op = OP_LBU;
            6'd37:   op = OP_LHU;
            6'd38:   op = OP_LWR;
            6'd40:   op = OP_SB;
            6'd41:   op = OP_SH;
            6'd43:   op = OP_SW;
            default: op = OP_NONE;
        endcase
    end

    // Immediate extension: logical immediates zero-extend, LUI shifts up, everything else sign-extends.
    always_comb begin
        imm = {{16{ir[15]}}, ir[15:0]};
        case (opcode)
            6'd12, 6'd13, 6'd14: imm = {16'h0, ir[15:0]};
            6'd15:               imm = {ir[15:0], 16'h0};
            default:             imm = {{16{ir[15]}}, ir[15:0]};
        endcase
    end

    // Write-back register: rd for SPECIAL, $31 for link ops, rt for the rest.
    always_comb begin
        dest = rt;
        if (opcode == 6'd0) begin
            dest = rd;
        end else if ((op == OP_JAL) || (op == OP_BLTZAL) || (op == OP_BGEZAL)) begin
            dest = 5'd31;
        end
    end

    // Ops that never write the register file; link branches write even when not taken.
    always_comb begin
        op_writes = 1'b1;
        case (op)
            OP_NONE,
            OP_DIV, OP_DIVU, OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO, OP_JR,
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ, OP_J,
            OP_SB, OP_SH, OP_SW: op_writes = 1'b0;
            default:             op_writes = 1'b1;
        endcase
    end

    // Strobe stays high for every EXEC2 cycle, including stalled load cycles.
    assign reg_write = exec2 && op_writes;

endmodule

// File: tb/tb_mips_decode_ctrl.sv
module tb_mips_decode_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        fetch, exec1, exec2, active, invalid;
    logic [6:0]  op;
    logic [5:0]  sa;
    logic [4:0]  rs, rt, dest;
    logic [31:0] imm;
    logic [25:0] target;
    logic        reg_write;

    mips_decode_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .fetch       (fetch),
        .exec1       (exec1),
        .exec2       (exec2),
        .active      (active),
        .invalid     (invalid),
        .op          (op),
        .sa          (sa),
        .rs          (rs),
        .rt          (rt),
        .dest        (dest),
        .imm         (imm),
        .target      (target),
        .reg_write   (reg_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rs, rt, dest;
        logic [5:0]  sa;
        logic [31:0] imm;
        logic [25:0] target;
        bit          wr;
        int          e2_len;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t cur;
    bit   have = 0;
    int   e2_cnt = 0;

    // Reference tables: encoding field value -> op number.
    int main_tab[int];
    int spec_tab[int];
    int regimm_tab[int];

    int spec_funcs[24]  = '{0,2,3,4,6,7,8,9,16,17,18,19,24,25,26,27,32,33,35,36,37,38,42,43};
    int main_codes[24]  = '{2,3,4,5,6,7,8,9,10,11,12,13,14,15,32,33,34,35,36,37,38,40,41,43};
    int regimm_rts[4]   = '{0,1,16,17};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] w, input int e2w);
        exp_t e;
        int opc = int'(w[31:26]);
        int fn  = int'(w[5:0]);
        int rtv = int'(w[20:16]);
        int o   = 0;
        if (opc == 0)      o = spec_tab.exists(fn)    ? spec_tab[fn]    : 0;
        else if (opc == 1) o = regimm_tab.exists(rtv) ? regimm_tab[rtv] : 0;
        else               o = main_tab.exists(opc)   ? main_tab[opc]   : 0;
        e.op     = 7'(o);
        e.rs     = w[25:21];
        e.rt     = w[20:16];
        e.sa     = {1'b0, w[10:6]};
        e.target = w[25:0];
        if (opc == 0)                          e.dest = w[15:11];
        else if (o == 39 || o == 32 || o == 36) e.dest = 5'd31;   // JAL, BGEZAL, BLTZAL
        else                                   e.dest = w[20:16];
        if (opc >= 12 && opc <= 14) e.imm = {16'h0, w[15:0]};
        else if (opc == 15)         e.imm = {w[15:0], 16'h0};
        else                        e.imm = {{16{w[15]}}, w[15:0]};
        // non-writers: DIV(U), MTHI/LO, MULT(U), plain branches, J, JR, stores
        e.wr     = (o != 0) && !(o inside {7, 8, 11, 12, 13, 14, 30, 31, 33, 34, 35, 37, 38, 41, 50, 51, 52});
        e.e2_len = (o >= 42 && o <= 52) ? 1 + e2w : 1;
        return e;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_fetch"},  fetch,     1);
        chk({tag, "_exec1"},  exec1,     0);
        chk({tag, "_exec2"},  exec2,     0);
        chk({tag, "_active"}, active,    1);
        chk({tag, "_inv"},    invalid,   0);
        chk({tag, "_op"},     op,        17);
        chk({tag, "_dest"},   dest,      0);
        chk({tag, "_imm"},    imm,       0);
        chk({tag, "_rw"},     reg_write, 0);
    endtask

    task automatic do_reset();
        waitrequest = 1'b1;
        reset = 1'b1;
        #1;
        q.delete();
        have = 0;
        chk_reset_vals("rst_async");
        @(posedge clk); #1;
        chk_reset_vals("rst_held");
        reset = 1'b0;
    endtask

    // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 in FETCH (or HALTED).
    task automatic run_instr(input logic [31:0] w, input int fw, input int ew);
        exp_t e = model(w, ew);
        bit   mem = (e.op >= 42);
        repeat (fw) begin
            waitrequest = 1'b1;
            readdata    = $urandom;
            @(posedge clk); #1;
        end
        waitrequest = 1'b0;
        readdata    = w;
        q.push_back(e);
        @(posedge clk); #1;
        waitrequest = 1'($urandom_range(0, 1));
        readdata    = $urandom;
        @(posedge clk); #1;
        if (e.op == 0) return;
        for (int i = 0; i < e.e2_len; i++) begin
            waitrequest = mem ? (i < e.e2_len - 1) : 1'($urandom_range(0, 1));
            readdata    = $urandom;
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 19);
        if (k < 7)       w[31:26] = 6'(main_codes[$urandom_range(0, 23)]);
        else if (k < 15) begin w[31:26] = 6'd0; w[5:0] = 6'(spec_funcs[$urandom_range(0, 23)]); end
        else if (k < 19) begin w[31:26] = 6'd1; w[20:16] = 5'(regimm_rts[$urandom_range(0, 3)]); end
        return w;
    endfunction

    // Monitor: pops one expectation per EXEC1 and follows that instruction to the next FETCH or HALTED.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset) continue;
            if (exec1) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL exec1_unexpected: got exec1=1 want no instruction pending");
                end else begin
                    cur = q.pop_front();
                    have = 1;
                    e2_cnt = 0;
                    chk("op", op, cur.op);
                    chk("rs", rs, cur.rs);
                    chk("rt", rt, cur.rt);
                    chk("sa", sa, cur.sa);
                    chk("dest", dest, cur.dest);
                    chk("imm", imm, cur.imm);
                    chk("target", target, cur.target);
                    chk("e1_rw", reg_write, 0);
                    chk("e1_onehot", {fetch, exec2, active}, 3'b001);
                end
            end else if (exec2) begin
                if (have) begin
                    e2_cnt++;
                    chk("e2_rw", reg_write, cur.wr);
                    chk("e2_op_hold", op, cur.op);
                    chk("e2_dest_hold", dest, cur.dest);
                    chk("e2_onehot", {fetch, exec1}, 2'b00);
                end
            end else if (fetch) begin
                if (have) begin
                    chk("e2_len", e2_cnt, cur.e2_len);
                    have = 0;
                end
            end else if (have) begin
                chk("halt_expected", cur.op, 0);
                chk("halt_inv", invalid, 1);
                chk("halt_active", active, 0);
                chk("halt_rw", reg_write, 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] w;
        exp_t e;
        main_tab[2]=38; main_tab[3]=39; main_tab[4]=30; main_tab[5]=37; main_tab[6]=34; main_tab[7]=33;
        main_tab[8]=2; main_tab[9]=3; main_tab[10]=20; main_tab[11]=21; main_tab[12]=6; main_tab[13]=16;
        main_tab[14]=29; main_tab[15]=46; main_tab[32]=42; main_tab[33]=44; main_tab[34]=48; main_tab[35]=47;
        main_tab[36]=43; main_tab[37]=45; main_tab[38]=49; main_tab[40]=50; main_tab[41]=51; main_tab[43]=52;
        regimm_tab[0]=35; regimm_tab[1]=31; regimm_tab[16]=36; regimm_tab[17]=32;
        spec_tab[0]=17; spec_tab[2]=25; spec_tab[3]=23; spec_tab[4]=18; spec_tab[6]=26; spec_tab[7]=24;
        spec_tab[8]=41; spec_tab[9]=40; spec_tab[16]=9; spec_tab[17]=11; spec_tab[18]=10; spec_tab[19]=12;
        spec_tab[24]=13; spec_tab[25]=14; spec_tab[26]=7; spec_tab[27]=8; spec_tab[32]=1; spec_tab[33]=4;
        spec_tab[35]=27; spec_tab[36]=5; spec_tab[37]=15; spec_tab[38]=28; spec_tab[42]=19; spec_tab[43]=22;

        readdata = 32'h0;
        do_reset();

        run_instr(32'h00851021, 0, 0);   // ADDU $2,$4,$5
        run_instr(32'h8C430008, 0, 2);   // LW $3,8($2), two EXEC2 stall cycles
        run_instr(32'h3C01ABCD, 0, 0);   // LUI
        run_instr(32'h3401FFFF, 0, 0);   // ORI
        run_instr(32'h2001FFFF, 0, 0);   // ADDI
        run_instr(32'h04110004, 1, 0);   // BGEZAL
        run_instr(32'hAC430004, 0, 3);   // SW with stalls
        run_instr(32'h00800008, 0, 0);   // JR $4

        // FETCH stall with a reset pulse inside the third stall cycle.
        waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            readdata = $urandom;
            if (i < 2) chk("fw_ir_hold", op, 41);
            if (i == 2) begin
                #1 reset = 1'b1;
                #1 chk("fw_rst_op", op, 17);
                chk("fw_rst_fetch", fetch, 1);
                reset = 1'b0;
            end
            @(posedge clk); #1;
            chk("fw_fetch", fetch, 1);
            if (i >= 2) chk("fw_op_zero", op, 17);
        end
        run_instr(32'h00851021, 0, 0);

        // Unsupported word: halts after EXEC1 and stays there.
        run_instr(32'hFC000000, 0, 0);
        for (int i = 0; i < 10; i++) begin
            waitrequest = 1'($urandom_range(0, 1));
            readdata    = $urandom;
            chk("halted_state", {fetch, exec1, exec2, active, invalid}, 5'b00001);
            chk("halted_rw", reg_write, 0);
            @(posedge clk); #1;
        end
        do_reset();

        for (int n = 0; n < 250; n++) begin
            w = ($urandom_range(0, 19) == 0) ? 32'($urandom) : rand_word();
            e = model(w, 0);
            run_instr(w, $urandom_range(0, 2), $urandom_range(0, 3));
            if (e.op == 0) begin
                repeat (2) @(posedge clk);
                #1;
                chk("rand_halt", {fetch, exec1, exec2, active, invalid}, 5'b00001);
                do_reset();
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("drain_q", q.size(), 0);
        chk("drain_have", have, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
